// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } arb_state_e;

  localparam int unsigned REQ_IF  = 0;
  localparam int unsigned REQ_MEM = 1;
  localparam int unsigned NUM_REQ = 2;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the core-side request/response lanes and the single downstream port.
// slave: the arbiter's view. master: the environment (requesters + downstream bridge).
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64
);
  // Core side, two requesters packed side by side
  logic [1:0]                  req_valid;
  logic [1:0]                  req_wen;
  logic [2*ADDR_WIDTH-1:0]     req_addr;
  logic [2*DATA_WIDTH-1:0]     req_wdata;
  logic [2*(DATA_WIDTH/8)-1:0] req_wmask;
  logic [1:0]                  req_ready;
  logic [1:0]                  rsp_valid;
  logic [DATA_WIDTH-1:0]       rsp_rdata;
  logic                        rsp_err;
  // Downstream side
  logic                        m_valid;
  logic                        m_ready;
  logic                        m_wen;
  logic [ADDR_WIDTH-1:0]       m_addr;
  logic [DATA_WIDTH-1:0]       m_wdata;
  logic [DATA_WIDTH/8-1:0]     m_wmask;
  logic                        m_rsp_valid;
  logic [DATA_WIDTH-1:0]       m_rsp_rdata;
  logic                        stray_rsp;

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output m_valid, m_wen, m_addr, m_wdata, m_wmask,
    input  m_ready, m_rsp_valid, m_rsp_rdata,
    output stray_rsp
  );

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  m_valid, m_wen, m_addr, m_wdata, m_wmask,
    output m_ready, m_rsp_valid, m_rsp_rdata,
    input  stray_rsp
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: favour the requester that did not win last time.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               last_grant_i,
  output logic               grant_o,
  output logic               any_req_o
);

  // Other requester wins if valid, otherwise fall back to the last winner
  always_comb begin
    any_req_o = |req_i;
    grant_o   = req_i[~last_grant_i] ? ~last_grant_i : last_grant_i;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between instruction fetch (0) and data (1).
// One transaction in flight; watchdog turns a silent downstream into an error response.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              rstn,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned MaskW = DATA_WIDTH / 8;
  localparam int unsigned CntW  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit          WdogEn = (TIMEOUT != 0);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] CntMax      = '1;

  arb_state_e            state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  grant_q, grant_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [MaskW-1:0]      wmask_q, wmask_d;
  logic [1:0]            rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  stray_q, stray_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic                  arb_grant;
  logic                  arb_any;
  logic [1:0]            req_ready;
  logic                  m_valid;
  logic                  wdog_expired;

  rr_arbiter2 u_rr (
    .req_i        (bus.req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_grant),
    .any_req_o    (arb_any)
  );

  // Next-state, holding-register capture, response generation and watchdog
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    wen_d        = wen_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    rsp_valid_d  = '0;
    rsp_rdata_d  = '0;
    rsp_err_d    = 1'b0;
    cnt_d        = cnt_q;
    req_ready    = '0;
    m_valid      = 1'b0;
    // Any downstream response outside WAIT_RSP has no owner; remember it
    stray_d      = stray_q | (bus.m_rsp_valid & (state_q != WAIT_RSP));
    wdog_expired = WdogEn && (cnt_q == TimeoutLast);

    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          req_ready = arb_grant ? 2'b10 : 2'b01;
          grant_d   = arb_grant;
          wen_d     = bus.req_wen[arb_grant];
          addr_d    = arb_grant ? bus.req_addr[2*ADDR_WIDTH-1 -: ADDR_WIDTH]
                                : bus.req_addr[ADDR_WIDTH-1:0];
          wdata_d   = arb_grant ? bus.req_wdata[2*DATA_WIDTH-1 -: DATA_WIDTH]
                                : bus.req_wdata[DATA_WIDTH-1:0];
          wmask_d   = arb_grant ? bus.req_wmask[2*MaskW-1 -: MaskW]
                                : bus.req_wmask[MaskW-1:0];
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        m_valid = 1'b1;
        if (bus.m_ready) begin
          cnt_d   = '0;
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
        // A real response beats a simultaneous watchdog expiry
        if (bus.m_rsp_valid) begin
          rsp_valid_d  = grant_q ? 2'b10 : 2'b01;
          rsp_rdata_d  = wen_q ? '0 : bus.m_rsp_rdata;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else if (wdog_expired) begin
          rsp_valid_d  = grant_q ? 2'b10 : 2'b01;
          rsp_err_d    = 1'b1;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and data registers; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'(REQ_MEM);
      grant_q      <= 1'b0;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      stray_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      stray_q      <= stray_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.m_valid   = m_valid;
  assign bus.m_wen     = wen_q;
  assign bus.m_addr    = addr_q;
  assign bus.m_wdata   = wdata_q;
  assign bus.m_wmask   = wmask_q;
  assign bus.stray_rsp = stray_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency, fairness, stall, watchdog, stray and reset.
module tb_mem_port_arbiter;

  localparam int unsigned AW  = 64;
  localparam int unsigned DW  = 64;
  localparam int unsigned TMO = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TMO)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid   = '0;
    bus.req_wen     = '0;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.req_wmask   = '0;
    bus.m_ready     = 1'b0;
    bus.m_rsp_valid = 1'b0;
    bus.m_rsp_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
    step();
  endtask

  logic       g;
  logic [1:0] oh;

  initial begin
    idle_inputs();
    #2;
    // Reset values
    chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_rsp_rdata", bus.rsp_rdata, 64'(0));
    chk("rst_rsp_err",   64'(bus.rsp_err), 64'(0));
    chk("rst_m_valid",   64'(bus.m_valid), 64'(0));
    chk("rst_m_addr",    bus.m_addr, 64'(0));
    chk("rst_m_wmask",   64'(bus.m_wmask), 64'(0));
    chk("rst_stray",     64'(bus.stray_rsp), 64'(0));
    step();
    rstn = 1'b1;
    step();

    // Single read from requester 0: ready at N, m_valid at N+1, response at N+3
    bus.req_valid         = 2'b01;
    bus.req_addr[63:0]    = 64'h8000_0000;
    #1;
    chk("rd_ready_N",  64'(bus.req_ready), 64'(2'b01));
    chk("rd_mvalid_N", 64'(bus.m_valid), 64'(0));
    step();
    bus.req_valid = 2'b00;
    bus.m_ready   = 1'b1;
    #1;
    chk("rd_mvalid_N1", 64'(bus.m_valid), 64'(1));
    chk("rd_maddr_N1",  bus.m_addr, 64'h8000_0000);
    chk("rd_mwen_N1",   64'(bus.m_wen), 64'(0));
    chk("rd_ready_N1",  64'(bus.req_ready), 64'(0));
    step();
    bus.m_ready     = 1'b0;
    bus.m_rsp_valid = 1'b1;
    bus.m_rsp_rdata = 64'hDEAD_BEEF;
    #1;
    chk("rd_mvalid_N2", 64'(bus.m_valid), 64'(0));
    chk("rd_rsp_N2",    64'(bus.rsp_valid), 64'(0));
    step();
    bus.m_rsp_valid = 1'b0;
    #1;
    chk("rd_rsp_N3",   64'(bus.rsp_valid), 64'(2'b01));
    chk("rd_rdata_N3", bus.rsp_rdata, 64'hDEAD_BEEF);
    chk("rd_err_N3",   64'(bus.rsp_err), 64'(0));
    step();
    chk("rd_rsp_N4",   64'(bus.rsp_valid), 64'(0));
    chk("rd_stray",    64'(bus.stray_rsp), 64'(0));

    // Both requesters valid from reset: grants alternate 0,1,0,1
    do_reset();
    bus.req_valid = 2'b11;
    bus.req_addr  = {64'h2000, 64'h1000};
    for (int i = 0; i < 4; i++) begin
      g  = 1'(i % 2);
      oh = g ? 2'b10 : 2'b01;
      #1;
      chk("fair_ready", 64'(bus.req_ready), 64'(oh));
      step();
      bus.m_ready = 1'b1;
      #1;
      chk("fair_maddr", bus.m_addr, g ? 64'h2000 : 64'h1000);
      step();
      bus.m_ready     = 1'b0;
      bus.m_rsp_valid = 1'b1;
      bus.m_rsp_rdata = 64'hA0 + 64'(i);
      step();
      bus.m_rsp_valid = 1'b0;
      if (i == 3) bus.req_valid = 2'b00;
      #1;
      chk("fair_rsp",   64'(bus.rsp_valid), 64'(oh));
      chk("fair_rdata", bus.rsp_rdata, 64'hA0 + 64'(i));
    end
    step();

    // Requester 1 write stalled by m_ready low for 5 cycles
    bus.req_valid         = 2'b10;
    bus.req_wen           = 2'b10;
    bus.req_addr          = {64'h3000_0040, 64'h1111};
    bus.req_wdata         = {64'h1122_3344_5566_7788, 64'h9999};
    bus.req_wmask         = {8'h0F, 8'hFF};
    #1;
    chk("wr_ready", 64'(bus.req_ready), 64'(2'b10));
    step();
    bus.req_valid = 2'b00;
    bus.req_addr  = '1;
    bus.req_wdata = '1;
    bus.req_wmask = '1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_mvalid", 64'(bus.m_valid), 64'(1));
      chk("stall_mwen",   64'(bus.m_wen), 64'(1));
      chk("stall_maddr",  bus.m_addr, 64'h3000_0040);
      chk("stall_mwdata", bus.m_wdata, 64'h1122_3344_5566_7788);
      chk("stall_mwmask", 64'(bus.m_wmask), 64'h0F);
      step();
    end
    bus.m_ready = 1'b1;
    #1;
    chk("wr_mvalid_hs", 64'(bus.m_valid), 64'(1));
    step();
    bus.m_ready     = 1'b0;
    bus.m_rsp_valid = 1'b1;
    bus.m_rsp_rdata = '1;
    step();
    bus.m_rsp_valid = 1'b0;
    #1;
    chk("wr_rsp",   64'(bus.rsp_valid), 64'(2'b10));
    chk("wr_rdata", bus.rsp_rdata, 64'(0));
    chk("wr_err",   64'(bus.rsp_err), 64'(0));
    step();

    // Downstream never answers: watchdog error after 8 WAIT_RSP cycles
    bus.req_wen         = 2'b00;
    bus.req_valid       = 2'b01;
    bus.req_addr[63:0]  = 64'h4000;
    #1;
    chk("tmo_ready", 64'(bus.req_ready), 64'(2'b01));
    step();
    bus.req_valid = 2'b00;
    bus.m_ready   = 1'b1;
    #1;
    chk("tmo_mvalid", 64'(bus.m_valid), 64'(1));
    step();
    bus.m_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("tmo_wait_rsp", 64'(bus.rsp_valid), 64'(0));
      step();
    end
    #1;
    chk("tmo_rsp",   64'(bus.rsp_valid), 64'(2'b01));
    chk("tmo_err",   64'(bus.rsp_err), 64'(1));
    chk("tmo_rdata", bus.rsp_rdata, 64'(0));
    step();
    chk("tmo_after_rsp", 64'(bus.rsp_valid), 64'(0));
    chk("tmo_after_err", 64'(bus.rsp_err), 64'(0));

    // Stray response while IDLE, then a normal transaction
    bus.m_rsp_valid = 1'b1;
    bus.m_rsp_rdata = 64'h5555;
    step();
    bus.m_rsp_valid = 1'b0;
    #1;
    chk("stray_set",    64'(bus.stray_rsp), 64'(1));
    chk("stray_no_rsp", 64'(bus.rsp_valid), 64'(0));
    bus.req_valid = 2'b11;
    bus.req_addr  = {64'h6000, 64'h5000};
    #1;
    chk("post_tmo_grant", 64'(bus.req_ready), 64'(2'b10));
    step();
    bus.req_valid = 2'b00;
    bus.m_ready   = 1'b1;
    #1;
    chk("post_stray_maddr", bus.m_addr, 64'h6000);
    step();
    bus.m_ready     = 1'b0;
    bus.m_rsp_valid = 1'b1;
    bus.m_rsp_rdata = 64'hCAFE_F00D_0000_0001;
    step();
    bus.m_rsp_valid = 1'b0;
    #1;
    chk("post_stray_rsp",   64'(bus.rsp_valid), 64'(2'b10));
    chk("post_stray_rdata", bus.rsp_rdata, 64'hCAFE_F00D_0000_0001);
    chk("post_stray_err",   64'(bus.rsp_err), 64'(0));
    chk("stray_sticky",     64'(bus.stray_rsp), 64'(1));
    step();

    // Reset asserted during WAIT_RSP
    bus.req_valid       = 2'b01;
    bus.req_addr[63:0]  = 64'h7000;
    #1;
    chk("mid_ready", 64'(bus.req_ready), 64'(2'b01));
    step();
    bus.req_valid = 2'b00;
    bus.m_ready   = 1'b1;
    step();
    bus.m_ready = 1'b0;
    #1;
    rstn = 1'b0;
    #1;
    chk("mid_rst_mvalid", 64'(bus.m_valid), 64'(0));
    chk("mid_rst_maddr",  bus.m_addr, 64'(0));
    chk("mid_rst_rsp",    64'(bus.rsp_valid), 64'(0));
    chk("mid_rst_stray",  64'(bus.stray_rsp), 64'(0));
    chk("mid_rst_ready",  64'(bus.req_ready), 64'(0));
    bus.m_rsp_valid = 1'b1;
    bus.m_rsp_rdata = 64'h7777;
    step();
    step();
    rstn = 1'b1;
    step();
    bus.m_rsp_valid = 1'b0;
    #1;
    chk("late_rsp_stray",  64'(bus.stray_rsp), 64'(1));
    chk("late_rsp_no_rsp", 64'(bus.rsp_valid), 64'(0));
    bus.req_valid = 2'b11;
    #1;
    chk("after_rst_grant", 64'(bus.req_ready), 64'(2'b01));
    step();
    idle_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
